freq_meter: RTL and testbench

Gated-count frequency meter clocked by the PLL output clock. Consumes the PLL `lock` flag and an asynchronous test signal, counts rising edges of the test signal over a fixed gate window of `clkin` cycles, and publishes the count with a one-cycle valid strobe. It sits directly downstream of the PLL in the frequency-measurement design and feeds the display/readout logic.

---
 rtl/freq_meter_pkg.sv | 13 +
 rtl/sync_edge.sv | 47 ++++
 rtl/freq_meter.sv | 176 +++++++++++++++++
 tb/tb_freq_meter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the gated-count frequency meter.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    GATE      = 2'd2
  } state_t;

  localparam int AVG_WINDOWS = 4;
  localparam int AVG_SHIFT   = 2;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with optional registered rising-edge output.
// RISE_OUT=1 gives a one-cycle pulse per rising edge, RISE_OUT=0 the synchronized level.
module sync_edge #(
  parameter bit RISE_OUT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s_p0;
  logic s_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_p0 <= 1'b0;
      s_p1 <= 1'b0;
    end else begin
      s_p0 <= d;
      s_p1 <= s_p0;
    end
  end

  generate
    if (RISE_OUT) begin : g_rise
      logic s_p2;
      logic rise_p2;

      // p1 -> p2: registered edge detect on the synchronized level
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s_p2    <= 1'b0;
          rise_p2 <= 1'b0;
        end else begin
          s_p2    <= s_p1;
          rise_p2 <= s_p1 & ~s_p2;
        end
      end

      assign q = rise_p2;
    end else begin : g_level
      assign q = s_p1;
    end
  endgenerate

endmodule

// File: rtl/freq_meter.sv
// Gated-count frequency meter: counts sig_in rising edges over GATE_CYCLES clkin cycles.
// Define FREQ_METER_AVG_EN to publish the average of every AVG_WINDOWS windows instead.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES   = 50_000_000,
  parameter int SETTLE_CYCLES = 1024,
  parameter int CNT_W         = 32
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             lock,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_out,
  output logic             freq_valid,
  output logic             freq_ovf,
  output logic             busy
);

  localparam int GATE_W   = $clog2(GATE_CYCLES);
  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [GATE_W-1:0]   GATE_LAST   = GATE_W'(GATE_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  // Returns {lost_edge, next_count}; the count sticks at all-ones.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
    if (inc && (&cnt))
      return {1'b1, cnt};
    else
      return {1'b0, cnt + CNT_W'(inc)};
  endfunction

  logic lock_s;
  logic sig_rise;

  sync_edge #(.RISE_OUT(1'b0)) u_lock_sync (
    .clk (clkin),
    .rst (reset),
    .d   (lock),
    .q   (lock_s)
  );

  sync_edge #(.RISE_OUT(1'b1)) u_sig_sync (
    .clk (clkin),
    .rst (reset),
    .d   (sig_in),
    .q   (sig_rise)
  );

  state_t              state;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [GATE_W-1:0]   gate_cnt;
  logic [CNT_W-1:0]    edge_cnt;
  logic                sat;

  logic [CNT_W:0]   inc_res;
  logic [CNT_W-1:0] win_cnt;
  logic             win_ovf;
  logic             win_last;

  // The closing cycle's edge is folded into the result so no edge is lost at the boundary.
  always_comb begin
    inc_res  = sat_inc(edge_cnt, sig_rise);
    win_cnt  = inc_res[CNT_W-1:0];
    win_ovf  = sat | inc_res[CNT_W];
    win_last = (gate_cnt == GATE_LAST);
  end

`ifdef FREQ_METER_AVG_EN
  localparam int ACC_W = CNT_W + AVG_SHIFT;
  localparam int IDX_W = $clog2(AVG_WINDOWS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(AVG_WINDOWS - 1);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [IDX_W-1:0] win_idx;
  logic             acc_ovf;

  assign acc_sum = acc + ACC_W'(win_cnt);
`endif

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state      <= WAIT_LOCK;
      settle_cnt <= '0;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      sat        <= 1'b0;
      freq_out   <= '0;
      freq_valid <= 1'b0;
      freq_ovf   <= 1'b0;
      busy       <= 1'b0;
`ifdef FREQ_METER_AVG_EN
      acc        <= '0;
      win_idx    <= '0;
      acc_ovf    <= 1'b0;
`endif
    end else begin
      freq_valid <= 1'b0;
      case (state)
        WAIT_LOCK: begin
          settle_cnt <= '0;
          gate_cnt   <= '0;
          edge_cnt   <= '0;
          sat        <= 1'b0;
          busy       <= 1'b0;
`ifdef FREQ_METER_AVG_EN
          acc        <= '0;
          win_idx    <= '0;
          acc_ovf    <= 1'b0;
`endif
          if (lock_s) state <= SETTLE;
        end

        SETTLE: begin
          if (!lock_s) begin
            state      <= WAIT_LOCK;
            settle_cnt <= '0;
          end else if (settle_cnt == SETTLE_LAST) begin
            state      <= GATE;
            settle_cnt <= '0;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            sat        <= 1'b0;
            busy       <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + SETTLE_W'(1);
          end
        end

        GATE: begin
          // Lock loss takes priority over a window closing in the same cycle.
          if (!lock_s) begin
            state    <= WAIT_LOCK;
            busy     <= 1'b0;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
          end else if (win_last) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
`ifdef FREQ_METER_AVG_EN
            if (win_idx == IDX_LAST) begin
              freq_out   <= CNT_W'(acc_sum >> AVG_SHIFT);
              freq_ovf   <= acc_ovf | win_ovf;
              freq_valid <= 1'b1;
              acc        <= '0;
              win_idx    <= '0;
              acc_ovf    <= 1'b0;
            end else begin
              acc        <= acc_sum;
              win_idx    <= win_idx + IDX_W'(1);
              acc_ovf    <= acc_ovf | win_ovf;
            end
`else
            freq_out   <= win_cnt;
            freq_ovf   <= win_ovf;
            freq_valid <= 1'b1;
`endif
          end else begin
            gate_cnt <= gate_cnt + GATE_W'(1);
            edge_cnt <= win_cnt;
            sat      <= win_ovf;
          end
        end

        default: begin
          state <= WAIT_LOCK;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: two instances (CNT_W=8 and CNT_W=5) share all stimulus.
// Build with FREQ_METER_AVG_EN defined to exercise the averaging variant.
module tb_freq_meter;

  localparam int G = 100;
  localparam int S = 8;

  logic       clkin  = 1'b0;
  logic       reset  = 1'b1;
  logic       lock   = 1'b0;
  logic       sig_in = 1'b0;
  logic [7:0] freq_out;
  logic       freq_valid, freq_ovf, busy;
  logic [4:0] freq_out5;
  logic       freq_valid5, freq_ovf5, busy5;

  freq_meter #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(8)) dut (
    .clkin(clkin), .reset(reset), .lock(lock), .sig_in(sig_in),
    .freq_out(freq_out), .freq_valid(freq_valid), .freq_ovf(freq_ovf), .busy(busy)
  );

  freq_meter #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(5)) dut5 (
    .clkin(clkin), .reset(reset), .lock(lock), .sig_in(sig_in),
    .freq_out(freq_out5), .freq_valid(freq_valid5), .freq_ovf(freq_ovf5), .busy(busy5)
  );

  always #5 clkin = ~clkin;

  // Strobe recorder: samples 1 time unit after each rising edge.
  int         cyc = 0, strobe_cnt = 0, strobe_cnt5 = 0, last_cyc = 0, prev_cyc = 0, dbl = 0;
  logic [7:0] last_out = '0;
  logic [4:0] last_out5 = '0;
  logic       last_ovf = 1'b0, last_ovf5 = 1'b0, prev_vld = 1'b0;

  initial begin
    forever begin
      @(posedge clkin);
      #1;
      cyc = cyc + 1;
      if (freq_valid) begin
        if (prev_vld) dbl = dbl + 1;
        strobe_cnt = strobe_cnt + 1;
        prev_cyc   = last_cyc;
        last_cyc   = cyc;
        last_out   = freq_out;
        last_ovf   = freq_ovf;
      end
      if (freq_valid5) begin
        strobe_cnt5 = strobe_cnt5 + 1;
        last_out5   = freq_out5;
        last_ovf5   = freq_ovf5;
      end
      prev_vld = freq_valid;
    end
  end

  int total = 0;
  int bad   = 0;
  int gen_period = 2;
  int ph = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input longint act, input longint lo, input longint hi);
    total = total + 1;
    if (act < lo || act > hi) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // One clock of periodic stimulus: period 0 holds high, negative holds low.
  task automatic step();
    if (gen_period == 0)
      sig_in = 1'b1;
    else if (gen_period < 0)
      sig_in = 1'b0;
    else
      sig_in = ((ph % gen_period) < (gen_period / 2));
    ph = ph + 1;
    @(negedge clkin);
  endtask

  task automatic run_until(input int k, input int budget, input string name);
    int target;
    int n;
    target = strobe_cnt + k;
    n = 0;
    while (strobe_cnt < target && n < budget) begin
      step();
      n = n + 1;
    end
    if (strobe_cnt < target) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL %s: no strobe within %0d cycles, strobes %0d, expected %0d", name, budget, strobe_cnt, target);
    end
  endtask

  // n single-cycle pulses placed well inside one 100-cycle window.
  task automatic pulses_in_window(input int n);
    for (int i = 0; i < G; i++) begin
      sig_in = (i >= 10) && (i < 10 + 2 * n) && (((i - 10) % 2) == 0);
      @(negedge clkin);
    end
  endtask

  typedef struct {
    int    period;
    int    out8;
    int    ovf8;
    int    out5;
    int    ovf5;
    string name;
  } vec_t;

  vec_t vec[6];
  int   rel;
  int   saved;

  initial begin
    vec[0] = '{10, 10, 0, 10, 0, "p10"};
    vec[1] = '{0,   0, 0,  0, 0, "held_high"};
    vec[2] = '{2,  50, 0, 31, 1, "toggle"};
    vec[3] = '{10, 10, 0, 10, 0, "p10_after_sat"};
    vec[4] = '{4,  25, 0, 25, 0, "p4"};
    vec[5] = '{5,  20, 0, 20, 0, "p5"};

    // Reset held with lock high and sig_in toggling: everything stays at zero.
    reset = 1'b1;
    lock  = 1'b1;
    gen_period = 2;
    @(negedge clkin);
    for (int i = 0; i < 150; i++) begin
      step();
      if (i % 50 == 10)
        chk("reset_hold_outputs", {freq_out, freq_valid, freq_ovf, busy, freq_out5, freq_valid5, freq_ovf5, busy5}, 0);
    end
    chk("reset_no_strobe", strobe_cnt, 0);

    reset = 1'b0;
    rel   = cyc;

`ifdef FREQ_METER_AVG_EN
    gen_period = -1;
    for (int i = 0; i < 60 && !busy; i++) step();
    chk("avg_gate_open", busy, 1);
    chk_range("avg_gate_latency", cyc - rel, S + 2, S + 4);

    saved = strobe_cnt;
    pulses_in_window(10);
    pulses_in_window(10);
    pulses_in_window(20);
    chk("avg_quiet_windows", strobe_cnt, saved);
    pulses_in_window(20);
    chk("avg1_strobe_count", strobe_cnt, saved + 1);
    chk("avg1_out", last_out, 15);
    chk("avg1_ovf", last_ovf, 0);
    chk("avg1_out5", last_out5, 15);
    chk("avg1_ovf5", last_ovf5, 0);

    saved = strobe_cnt;
    pulses_in_window(40);
    pulses_in_window(40);
    pulses_in_window(40);
    chk("avg2_quiet_windows", strobe_cnt, saved);
    pulses_in_window(40);
    chk("avg2_strobe_count", strobe_cnt, saved + 1);
    chk("avg2_out", last_out, 40);
    chk("avg2_ovf", last_ovf, 0);
    chk("avg2_out5", last_out5, 31);
    chk("avg2_ovf5", last_ovf5, 1);
`else
    gen_period = vec[0].period;
    run_until(1, 200, "first_strobe");
    chk_range("first_strobe_latency", last_cyc - rel, G + S + 1, G + S + 4);

    for (int r = 0; r < 6; r++) begin
      gen_period = vec[r].period;
      run_until(2, 2 * G + 20, vec[r].name);
      chk({vec[r].name, "_out"}, last_out, vec[r].out8);
      chk({vec[r].name, "_ovf"}, last_ovf, vec[r].ovf8);
      chk({vec[r].name, "_out5"}, last_out5, vec[r].out5);
      chk({vec[r].name, "_ovf5"}, last_ovf5, vec[r].ovf5);
      chk({vec[r].name, "_spacing"}, last_cyc - prev_cyc, G);
    end
    chk("busy_in_gate", busy, 1);

    // Lock lost mid-window: partial window discarded, last result held.
    gen_period = 10;
    run_until(2, 2 * G + 20, "pre_abort");
    for (int i = 0; i < 48; i++) step();
    lock  = 1'b0;
    saved = strobe_cnt;
    for (int i = 0; i < 150; i++) step();
    chk("abort_no_strobe", strobe_cnt, saved);
    chk("abort_busy", busy, 0);
    chk("abort_busy5", busy5, 0);
    chk("abort_hold_out", freq_out, 10);
    chk("abort_hold_ovf", freq_ovf, 0);

    lock = 1'b1;
    rel  = cyc;
    run_until(1, 200, "relock_strobe");
    chk_range("relock_latency", last_cyc - rel, G + S + 1, G + S + 4);
    chk("relock_out", last_out, 10);
    chk("relock_out5", last_out5, 10);

    // Asynchronous reset in mid-window clears outputs before the next clock edge.
    for (int i = 0; i < 37; i++) step();
    chk("pre_reset_out", freq_out, 10);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", {freq_out, freq_valid, freq_ovf, busy, freq_out5, freq_valid5, freq_ovf5, busy5}, 0);
    @(negedge clkin);
    for (int i = 0; i < 5; i++) step();
    reset = 1'b0;
    rel   = cyc;
    run_until(1, 200, "post_reset_strobe");
    chk_range("post_reset_latency", last_cyc - rel, G + S + 1, G + S + 4);
    chk("post_reset_out", last_out, 10);
`endif

    chk("no_back_to_back_valid", dbl, 0);
    chk("dut5_strobe_count", strobe_cnt5, strobe_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
